uart_tx_scheduler: RTL and testbench

Shares one tx_control UART transmitter between N_REQ byte-stream requesters. Arbitration is round-robin and happens only at frame boundaries. The block prefetches bytes into a one-deep hold register and drives tx_data and tx_enable_signal so that consecutive bytes go out back-to-back. It sits between the packet sources and tx_control, and consumes tx_done_signal and bps_clk_total.

---
 rtl/uart_tx_pkg.sv | 12 +
 rtl/uart_tx_scheduler_if.sv | 30 +++
 rtl/uart_rr_arbiter.sv | 32 +++
 rtl/uart_tx_scheduler.sv | 135 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared constants for the UART transmit scheduler
package uart_tx_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int ID_W_DEF  = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_UWAIT = 2'd2;
    localparam logic [1:0] ST_END   = 2'd3;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester, tx_control and status signals of the scheduler
interface uart_tx_scheduler_if
    import uart_tx_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = ID_W_DEF
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [7:0]         tx_data;
    logic               tx_enable_signal;
    logic               tx_done_signal;
    logic               bps_clk_total;
    logic               busy;
    logic [ID_W-1:0]    grant_id;
    logic               frame_done;
    logic               underrun;

    modport master (
        input  req_valid, req_data, req_last, tx_done_signal, bps_clk_total,
        output req_ready, tx_data, tx_enable_signal, busy, grant_id, frame_done, underrun
    );

    modport slave (
        output req_valid, req_data, req_last, tx_done_signal, bps_clk_total,
        input  req_ready, tx_data, tx_enable_signal, busy, grant_id, frame_done, underrun
    );
endinterface

// File: rtl/uart_rr_arbiter.sv
// rtl/uart_rr_arbiter.sv - combinational round-robin pick starting just above the pointer
module uart_rr_arbiter
    import uart_tx_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]  o_id,
    output logic             o_valid
);
    int w_idx;

    // Walk from the farthest offset down so the nearest requester above the pointer wins.
    always_comb begin
        o_gnt   = '0;
        o_id    = '0;
        o_valid = 1'b0;
        w_idx   = 0;
        for (int off = N_REQ; off >= 1; off--) begin
            w_idx = (int'(i_ptr) + off) % N_REQ;
            if (i_req[w_idx]) begin
                o_valid      = 1'b1;
                o_id         = ID_W'(w_idx);
                o_gnt        = '0;
                o_gnt[w_idx] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - shares one tx_control between requesters, frame-level round robin
module uart_tx_scheduler
    import uart_tx_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    uart_tx_scheduler_if.master bus
);
    logic [1:0]       r_state;
    logic [7:0]       r_tx_data;
    logic [7:0]       r_hold;
    logic             r_hold_last;
    logic             r_hold_full;
    logic             r_cur_last;
    logic             r_en;
    logic             r_busy;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_grant;

    logic [N_REQ-1:0] w_arb_gnt;
    logic [ID_W-1:0]  w_arb_id;
    logic             w_arb_valid;
    logic [N_REQ-1:0] w_ready;
    logic [ID_W-1:0]  w_sel_id;
    logic             w_accept;
    logic [7:0]       w_acc_data;
    logic             w_acc_last;
    logic             w_bps_exit;

    uart_rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .o_gnt   (w_arb_gnt),
        .o_id    (w_arb_id),
        .o_valid (w_arb_valid)
    );

    always_comb begin
        w_ready = '0;
        case (r_state)
            ST_IDLE:  w_ready = w_arb_gnt;
            ST_SEND:  w_ready[r_grant] = !r_hold_full && !r_cur_last;
            ST_UWAIT: w_ready[r_grant] = 1'b1;
            default:  w_ready = '0;
        endcase
    end

    assign w_sel_id   = (r_state == ST_IDLE) ? w_arb_id : r_grant;
    assign w_accept   = |(w_ready & bus.req_valid);
    assign w_acc_data = bus.req_data[8*int'(w_sel_id) +: 8];
    assign w_acc_last = bus.req_last[w_sel_id];

    // Dropping enable in the closing bit strobe steers tx_control to IDLE instead of a new start bit.
    assign w_bps_exit = ((r_state == ST_UWAIT) || (r_state == ST_END)) && bus.bps_clk_total && !w_accept;

    assign bus.tx_enable_signal = r_en && !w_bps_exit;
    assign bus.req_ready        = w_ready & {N_REQ{rst_n}};
    assign bus.tx_data          = r_tx_data;
    assign bus.busy             = r_busy;
    assign bus.grant_id         = r_grant;
    assign bus.frame_done       = (r_state == ST_END) && bus.bps_clk_total;
    assign bus.underrun         = (r_state == ST_UWAIT) && bus.bps_clk_total && !w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_tx_data   <= '0;
            r_hold      <= '0;
            r_hold_last <= 1'b0;
            r_hold_full <= 1'b0;
            r_cur_last  <= 1'b0;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
            r_ptr       <= ID_W'(N_REQ - 1);
            r_grant     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_arb_valid) begin
                        r_tx_data  <= w_acc_data;
                        r_cur_last <= w_acc_last;
                        r_grant    <= w_arb_id;
                        r_ptr      <= w_arb_id;
                        r_busy     <= 1'b1;
                        r_en       <= 1'b1;
                        r_state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (bus.tx_done_signal) begin
                        if (r_cur_last) begin
                            r_state <= ST_END;
                        end else if (r_hold_full) begin
                            r_tx_data   <= r_hold;
                            r_cur_last  <= r_hold_last;
                            r_hold_full <= 1'b0;
                        end else if (w_accept) begin
                            // Byte arriving exactly in the done cycle bypasses the hold register.
                            r_tx_data  <= w_acc_data;
                            r_cur_last <= w_acc_last;
                        end else begin
                            r_state <= ST_UWAIT;
                        end
                    end else if (w_accept) begin
                        r_hold      <= w_acc_data;
                        r_hold_last <= w_acc_last;
                        r_hold_full <= 1'b1;
                    end
                end
                ST_UWAIT: begin
                    if (w_accept) begin
                        r_tx_data  <= w_acc_data;
                        r_cur_last <= w_acc_last;
                        r_state    <= ST_SEND;
                    end else if (bus.bps_clk_total) begin
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_END: begin
                    if (bus.bps_clk_total) begin
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - directed bench with a tx_control line model
module tb_uart_tx_scheduler;
    localparam int BPS  = 8;
    localparam int MAXW = 3000;
    localparam int M_IDLE = 0, M_START = 1, M_DATA = 2, M_STOP = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.N_REQ(4), .ID_W(2)) bus ();

    uart_tx_scheduler #(.N_REQ(4), .ID_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Bit-period strobe and a minimal tx_control that reads tx_data live.
    int bps_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bps_cnt <= 0;
        else        bps_cnt <= (bps_cnt == BPS - 1) ? 0 : bps_cnt + 1;
    end
    assign bus.bps_clk_total = (bps_cnt == BPS - 1);

    int         m_st;
    int         m_bit;
    logic       m_line;
    logic [7:0] m_cap;
    logic [7:0] prev_tx;
    logic [7:0] cap_q[$];
    int n_idle_start = 0, n_back2back = 0, n_stop_idle = 0, stab_err = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st               <= M_IDLE;
            m_bit              <= 0;
            m_line             <= 1'b1;
            bus.tx_done_signal <= 1'b0;
            prev_tx            <= '0;
        end else begin
            bus.tx_done_signal <= 1'b0;
            prev_tx            <= bus.tx_data;
            if (m_st == M_DATA && bus.tx_data !== prev_tx) stab_err <= stab_err + 1;
            if (bus.bps_clk_total) begin
                case (m_st)
                    M_IDLE: if (bus.tx_enable_signal) begin
                        m_st <= M_START; m_line <= 1'b0; n_idle_start <= n_idle_start + 1;
                    end
                    M_START: begin
                        m_st <= M_DATA; m_bit <= 0;
                        m_line <= bus.tx_data[0]; m_cap[0] <= bus.tx_data[0];
                    end
                    M_DATA: if (m_bit < 7) begin
                        m_bit <= m_bit + 1;
                        m_line <= bus.tx_data[m_bit+1]; m_cap[m_bit+1] <= bus.tx_data[m_bit+1];
                    end else begin
                        m_st <= M_STOP; m_line <= 1'b1; bus.tx_done_signal <= 1'b1;
                        cap_q.push_back(m_cap);
                    end
                    default: if (bus.tx_enable_signal) begin
                        m_st <= M_START; m_line <= 1'b0; n_back2back <= n_back2back + 1;
                    end else begin
                        m_st <= M_IDLE; n_stop_idle <= n_stop_idle + 1;
                    end
                endcase
            end
        end
    end

    int         fd_cnt = 0, ur_cnt = 0, lock_viol = 0;
    logic [1:0] fd_ids[$];
    always @(posedge clk) begin
        if (rst_n) begin
            if (bus.frame_done) begin
                fd_cnt <= fd_cnt + 1;
                fd_ids.push_back(bus.grant_id);
            end
            if (bus.underrun) ur_cnt <= ur_cnt + 1;
            if (bus.busy && ((bus.req_ready & ~(4'b0001 << bus.grant_id)) != 4'b0000))
                lock_viol <= lock_viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_accept(input int idx, input string tag);
        logic ok = 1'b0;
        for (int k = 0; k < MAXW; k++) begin
            @(negedge clk);
            if (bus.req_ready[idx] && bus.req_valid[idx]) begin ok = 1'b1; break; end
        end
        chk(tag, 32'(ok), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send(input int idx, input logic [7:0] d, input logic l, input string tag);
        bus.req_valid[idx]      = 1'b1;
        bus.req_data[8*idx +: 8] = d;
        bus.req_last[idx]       = l;
        wait_accept(idx, tag);
    endtask

    task automatic wait_fd(input string tag);
        logic ok = 1'b0;
        for (int k = 0; k < MAXW; k++) begin
            @(negedge clk);
            if (bus.frame_done) begin ok = 1'b1; break; end
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    int s_is, s_bb, s_si, s_ur, s_fd;
    logic ok_w;

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        repeat (3) @(posedge clk); #1;
        bus.req_valid[0] = 1'b1;
        #1;
        chk("rst_tx_enable", 32'(bus.tx_enable_signal), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_frame_done", 32'(bus.frame_done), 32'd0);
        chk("rst_underrun", 32'(bus.underrun), 32'd0);
        bus.req_valid[0] = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Two-byte frame from requester 0, sent back-to-back
        s_is = n_idle_start; s_bb = n_back2back; s_si = n_stop_idle;
        send(0, 8'hA5, 1'b0, "t1_acc_a5");
        chk("t1_grant", 32'(bus.grant_id), 32'd0);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        send(0, 8'h3C, 1'b1, "t1_acc_3c");
        bus.req_valid[0] = 1'b0;
        wait_fd("t1_fd_seen");
        chk("t1_en_low_final", 32'(bus.tx_enable_signal), 32'd0);
        chk("t1_fd_grant", 32'(bus.grant_id), 32'd0);
        @(posedge clk); #1;
        chk("t1_busy_clr", 32'(bus.busy), 32'd0);
        chk("t1_byte0", 32'(cap_q.pop_front()), 32'hA5);
        chk("t1_byte1", 32'(cap_q.pop_front()), 32'h3C);
        chk("t1_one_start", 32'(n_idle_start - s_is), 32'd1);
        chk("t1_no_gap", 32'(n_back2back - s_bb), 32'd1);
        chk("t1_one_idle", 32'(n_stop_idle - s_si), 32'd1);
        chk("t1_fd_count", 32'(fd_cnt), 32'd1);

        // Simultaneous single-byte frames from requesters 1 and 3, twice
        pulse_reset();
        fd_ids.delete();
        for (int r = 0; r < 2; r++) begin
            bus.req_data[15:8] = 8'h51; bus.req_last[1] = 1'b1; bus.req_valid[1] = 1'b1;
            bus.req_data[31:24] = 8'h53; bus.req_last[3] = 1'b1; bus.req_valid[3] = 1'b1;
            wait_accept(1, "t2_acc_r1");
            bus.req_valid[1] = 1'b0;
            wait_accept(3, "t2_acc_r3");
            bus.req_valid[3] = 1'b0;
            wait_fd("t2_fd_seen");
            @(posedge clk); #1;
        end
        chk("t2_nfd", 32'(fd_ids.size()), 32'd4);
        chk("t2_order0", 32'(fd_ids[0]), 32'd1);
        chk("t2_order1", 32'(fd_ids[1]), 32'd3);
        chk("t2_order2", 32'(fd_ids[2]), 32'd1);
        chk("t2_order3", 32'(fd_ids[3]), 32'd3);
        chk("t2_bytes", {cap_q[0], cap_q[1], cap_q[2], cap_q[3]}, 32'h51535153);
        cap_q.delete();

        // Grant stays locked on requester 0 for its whole three-byte frame
        fd_ids.delete();
        bus.req_data[15:8] = 8'h61; bus.req_last[1] = 1'b1; bus.req_valid[1] = 1'b1;
        send(0, 8'h01, 1'b0, "t3_acc_b0");
        send(0, 8'h02, 1'b0, "t3_acc_b1");
        send(0, 8'h03, 1'b1, "t3_acc_b2");
        bus.req_valid[0] = 1'b0;
        wait_fd("t3_fd0_seen");
        chk("t3_fd0_grant", 32'(bus.grant_id), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_next_idle_ready", 32'(bus.req_ready), 32'b0010);
        @(posedge clk); #1;
        bus.req_valid[1] = 1'b0;
        wait_fd("t3_fd1_seen");
        chk("t3_fd1_grant", 32'(bus.grant_id), 32'd1);
        @(posedge clk); #1;
        chk("t3_lock", 32'(lock_viol), 32'd0);
        chk("t3_bytes", {cap_q[0], cap_q[1], cap_q[2], cap_q[3]}, 32'h01020361);
        cap_q.delete();

        // Requester 2 runs dry after one byte: underrun
        s_ur = ur_cnt; s_fd = fd_cnt;
        send(2, 8'h11, 1'b0, "t4_acc");
        bus.req_valid[2] = 1'b0;
        ok_w = 1'b0;
        for (int k = 0; k < MAXW; k++) begin
            @(negedge clk);
            if (bus.underrun) begin ok_w = 1'b1; break; end
        end
        chk("t4_ur_seen", 32'(ok_w), 32'd1);
        chk("t4_en_low", 32'(bus.tx_enable_signal), 32'd0);
        chk("t4_busy_before", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        chk("t4_busy_clr", 32'(bus.busy), 32'd0);
        chk("t4_ur_count", 32'(ur_cnt - s_ur), 32'd1);
        repeat (2 * BPS) @(posedge clk); #1;
        chk("t4_line_idle", 32'(m_line), 32'd1);
        chk("t4_ur_once", 32'(ur_cnt - s_ur), 32'd1);
        chk("t4_no_fd", 32'(fd_cnt - s_fd), 32'd0);
        chk("t4_byte", 32'(cap_q.pop_front()), 32'h11);

        // Late byte rescues the frame in the underrun wait
        s_ur = ur_cnt;
        send(2, 8'h11, 1'b0, "t5_acc0");
        bus.req_valid[2] = 1'b0;
        ok_w = 1'b0;
        for (int k = 0; k < MAXW; k++) begin
            @(negedge clk);
            if (bus.tx_done_signal) begin ok_w = 1'b1; break; end
        end
        chk("t5_done_seen", 32'(ok_w), 32'd1);
        repeat (2) @(posedge clk); #1;
        send(2, 8'h22, 1'b1, "t5_acc1");
        bus.req_valid[2] = 1'b0;
        chk("t5_busy", 32'(bus.busy), 32'd1);
        wait_fd("t5_fd_seen");
        chk("t5_fd_grant", 32'(bus.grant_id), 32'd2);
        @(posedge clk); #1;
        chk("t5_no_ur", 32'(ur_cnt - s_ur), 32'd0);
        chk("t5_bytes", {16'h0, cap_q[0], cap_q[1]}, 32'h1122);
        cap_q.delete();

        // Reset during data bit 4
        pulse_reset();
        bus.req_data[7:0] = 8'h77; bus.req_last[0] = 1'b1; bus.req_valid[0] = 1'b1;
        wait_accept(0, "t6_acc0");
        ok_w = 1'b0;
        for (int k = 0; k < MAXW; k++) begin
            @(negedge clk);
            if (m_st == M_DATA && m_bit == 4) begin ok_w = 1'b1; break; end
        end
        chk("t6_bit4_seen", 32'(ok_w), 32'd1);
        bus.req_data[31:24] = 8'h78; bus.req_last[3] = 1'b1; bus.req_valid[3] = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_en_async", 32'(bus.tx_enable_signal), 32'd0);
        chk("t6_ready_async", 32'(bus.req_ready), 32'd0);
        chk("t6_busy_async", 32'(bus.busy), 32'd0);
        chk("t6_txdata_async", 32'(bus.tx_data), 32'd0);
        chk("t6_no_partial", 32'(cap_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("t6_first_pick", 32'(bus.req_ready), 32'b0001);
        @(posedge clk); #1;
        bus.req_valid[0] = 1'b0;
        wait_fd("t6_fd0_seen");
        chk("t6_fd0_grant", 32'(bus.grant_id), 32'd0);
        @(posedge clk); #1;
        wait_accept(3, "t6_acc3");
        bus.req_valid[3] = 1'b0;
        wait_fd("t6_fd3_seen");
        chk("t6_fd3_grant", 32'(bus.grant_id), 32'd3);
        @(posedge clk); #1;
        chk("t6_bytes", {16'h0, cap_q[0], cap_q[1]}, 32'h7778);

        chk("tx_data_stable", 32'(stab_err), 32'd0);
        chk("grant_lock_total", 32'(lock_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
